pipe_fifo_stage: RTL

//   Parametrised elastic pipeline stage. Successor of the fixed LSU->WBU stage register.

---
 rtl/pipe_fifo_stage_pkg.sv | 18 +
 rtl/pipe_fifo_stage_sat_cnt.sv | 20 ++
 rtl/pipe_fifo_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/pipe_fifo_stage_pkg.sv
// Shared definitions for pipe_fifo_stage: LSU->WBU payload layout and statistics width.
// Producers/consumers pack fields with these offsets; the stage itself treats the payload as opaque.
package pipe_fifo_stage_pkg;

    localparam int LSWB_INST_LSB      = 0;
    localparam int LSWB_PC_LSB        = 32;
    localparam int LSWB_REG_WE_BIT    = 64;
    localparam int LSWB_WADDR_LSB     = 65;
    localparam int LSWB_WDATA_LSB     = 70;
    localparam int LSWB_CSR_WE_BIT    = 102;
    localparam int LSWB_CSR_WADDR_LSB = 103;
    localparam int LSWB_CSR_WDATA_LSB = 135;
    // Bits above the CSR write data are spare room for future fields.
    localparam int LSWB_DATA_W        = 198;

    localparam int STAT_W = 32;

endpackage

// File: rtl/pipe_fifo_stage_sat_cnt.sv
// pipe_sat_cnt: saturating event counter used for the optional stage statistics.
// Cleared only by rst_n; holds at all-ones once reached.
module pipe_sat_cnt
    import pipe_fifo_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [STAT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + STAT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_fifo_stage.sv
// pipe_fifo_stage: elastic DEPTH-entry valid/ready pipeline stage with an opaque payload.
// Optional statistics (stall and full cycle counters) are built when PIPE_FIFO_STAT_EN is defined.
module pipe_fifo_stage
    import pipe_fifo_stage_pkg::*;
#(
    parameter int DATA_W = LSWB_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_FIFO_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_stall_cnt_o,
    output logic [STAT_W-1:0] stat_full_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("pipe_fifo_stage: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high and
    // flush_i is low. Both ready and valid come from cnt alone, so nothing combinational
    // crosses the stage and out_data_o stays put while the consumer backpressures.
    assign in_ready_o  = (cnt != FULL_CNT);
    assign out_valid_o = (cnt != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Stale mem contents are harmless: the output is masked while cnt==0.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef PIPE_FIFO_STAT_EN
    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_valid_o & ~out_ready_i),
        .cnt   (stat_stall_cnt_o)
    );

    pipe_sat_cnt u_full_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt == FULL_CNT),
        .cnt   (stat_full_cnt_o)
    );
`endif

endmodule
